// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Sequences the pipeline's response to a branch resolved in EX. Each resolved
// branch is evaluated and compared with the fetch-stage prediction. On a
// mispredict the controller flushes IF/ID, stalls EX and then offers the
// corrected PC to fetch over a valid/ready handshake. It also keeps
// saturating branch and mispredict counters.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ex_valid_i            EX holds a resolved instruction this cycle
//   ex_branch_cond_i      0 non-branch, 1 taken if alu!=0, 2 taken if alu==0, 3 jump
//   ex_alu_out_i          ALU comparison result
//   ex_target_i           branch/jump target PC
//   ex_fallthrough_i      PC+4 of the EX instruction
//   ex_pred_taken_i       fetch-stage prediction
//   redirect_ready_i      fetch accepts the redirect
//   ex_stall_o            hold EX and upstream
//   flush_if_o/flush_id_o squash IF/ID
//   redirect_valid_o      redirect_pc_o is valid
//   redirect_pc_o         corrected fetch PC
//   branch_count_o        resolved branches/jumps (saturating)
//   mispredict_count_o    mispredicts (saturating)
//
// state    | meaning
// IDLE     | evaluating EX each cycle, no stall
// FLUSH    | squashing IF/ID for FlushCycles cycles, EX stalled
// REDIRECT | offering redirect_pc to fetch, EX stalled until accepted
module branch_redirect_ctrl #(
  parameter int unsigned WordSize    = 32,
  parameter int unsigned FlushCycles = 2,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ex_valid_i,
  input  logic [1:0]          ex_branch_cond_i,
  input  logic [WordSize-1:0] ex_alu_out_i,
  input  logic [WordSize-1:0] ex_target_i,
  input  logic [WordSize-1:0] ex_fallthrough_i,
  input  logic                ex_pred_taken_i,
  input  logic                redirect_ready_i,
  output logic                ex_stall_o,
  output logic                flush_if_o,
  output logic                flush_id_o,
  output logic                redirect_valid_o,
  output logic [WordSize-1:0] redirect_pc_o,
  output logic [CntWidth-1:0] branch_count_o,
  output logic [CntWidth-1:0] mispredict_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REDIRECT
  } state_e;

  localparam logic [3:0]          FlushLoad = 4'(FlushCycles);
  localparam logic [CntWidth-1:0] CntMax    = '1;

  state_e              state_q, state_d;
  logic [3:0]          flush_cnt_q, flush_cnt_d;
  logic [WordSize-1:0] redirect_pc_q, redirect_pc_d;
  logic [CntWidth-1:0] branch_cnt_q, branch_cnt_d;
  logic [CntWidth-1:0] mispred_cnt_q, mispred_cnt_d;
  logic                taken;
  logic                mispredict;

  always_comb begin
    taken = 1'b0;
    unique case (ex_branch_cond_i)
      2'd0:    taken = 1'b0;
      2'd1:    taken = |ex_alu_out_i;
      2'd2:    taken = ~|ex_alu_out_i;
      default: taken = 1'b1;
    endcase
  end

  // A non-branch predicted taken is also a mispredict: fetch went off-path.
  assign mispredict = ex_valid_i & (taken != ex_pred_taken_i);

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_pc_d = redirect_pc_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // EX inputs are only meaningful here; elsewhere upstream is stalled.
        if (ex_valid_i) begin
          if ((ex_branch_cond_i != 2'd0) && (branch_cnt_q != CntMax)) begin
            branch_cnt_d = branch_cnt_q + CntWidth'(1);
          end
          if (mispredict && (mispred_cnt_q != CntMax)) begin
            mispred_cnt_d = mispred_cnt_q + CntWidth'(1);
          end
        end
        if (mispredict) begin
          redirect_pc_d = taken ? ex_target_i : ex_fallthrough_i;
          flush_cnt_d   = FlushLoad;
          state_d       = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Counter value 1 marks the last flush cycle.
        if (flush_cnt_q == 4'd1) begin
          state_d = ST_REDIRECT;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= '0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign ex_stall_o         = (state_q != ST_IDLE);
  assign flush_if_o         = (state_q == ST_FLUSH);
  assign flush_id_o         = (state_q == ST_FLUSH);
  assign redirect_valid_o   = (state_q == ST_REDIRECT);
  assign redirect_pc_o      = redirect_pc_q;
  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispred_cnt_q;

endmodule
